// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller: stall vector
// width and stage bit positions, the encoded stall patterns driven onto the
// stage registers, the controller FSM state type and the reset polarity.
// No ports; imported by the interface, the controller and its counter.
package pipeline_ctrl_pkg;

  localparam int PIPE_N = 6;

  // Bit positions inside the stall vector
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A stage register bubbles when its own bit is set and the next bit is
  // clear, so each pattern's highest set bit picks the stage that bubbles.
  localparam logic [PIPE_N-1:0] STALL_PAT_NONE = 6'b000000;
  localparam logic [PIPE_N-1:0] STALL_PAT_IF   = 6'b000011;
  localparam logic [PIPE_N-1:0] STALL_PAT_ID   = 6'b000111;
  localparam logic [PIPE_N-1:0] STALL_PAT_MEM  = 6'b011111;

  localparam logic RESET_ENABLE = 1'b1;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundles the stall requests coming from the stages and the stall/flush
// controls plus debug/performance outputs going back to them.
//   master : the controller (receives requests, drives stall/flush/counters)
//   slave  : the pipeline side (drives requests, receives controls)
// Parameter CNT_W sets the width of the two performance counters.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic              if_stall_req;
  logic              if_fetch_done;
  logic              id_stall_req;
  logic              mem_stall_req;
  logic              ex_jump;
  logic [PIPE_N-1:0] stall_o;
  logic              flush_o;
  logic              discard_fetch_o;
  logic              drain_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  flush_count_o;

  modport master (
    input  if_stall_req, if_fetch_done, id_stall_req, mem_stall_req, ex_jump,
    output stall_o, flush_o, discard_fetch_o, drain_o,
           stall_cycles_o, flush_count_o
  );

  modport slave (
    output if_stall_req, if_fetch_done, id_stall_req, mem_stall_req, ex_jump,
    input  stall_o, flush_o, discard_fetch_o, drain_o,
           stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Up-counter that stops at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   clear : synchronous clear to zero (takes priority over inc)
//   inc   : count one this cycle
//   count : current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush controller for the 5-stage pipeline. Arbitrates stall
// requests from IF, ID and MEM against the EX redirect, tracks a fetch that
// is still in flight when a redirect happens (DRAIN state) so its data is
// dropped, and keeps saturating stall/flush cycle counters.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : pipeline_ctrl_if.master (requests in; stall/flush/discard/drain and
//         counters out)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_if.master  bus
);

  pc_state_e         state;
  pc_state_e         state_next;
  logic [PIPE_N-1:0] stall;
  logic              flush;
  logic              discard;
  logic              in_reset;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  assign in_reset = (rst == RESET_ENABLE);

  // State register
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state <= PC_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      PC_RUN: begin
        // A MEM stall freezes EX, so a concurrent jump is replayed later and
        // must not start a drain now.
        if (!bus.mem_stall_req && bus.ex_jump &&
            bus.if_stall_req && !bus.if_fetch_done) begin
          state_next = PC_DRAIN;
        end
      end
      PC_DRAIN: begin
        if (bus.if_fetch_done) begin
          state_next = PC_RUN;
        end
      end
      default: state_next = PC_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    stall   = STALL_PAT_NONE;
    flush   = 1'b0;
    discard = 1'b0;
    if (!in_reset) begin
      case (state)
        PC_RUN: begin
          if (bus.mem_stall_req) begin
            stall = STALL_PAT_MEM;
          end else if (bus.ex_jump) begin
            flush   = 1'b1;
            // Data returning in the redirect cycle belongs to the wrong path.
            discard = bus.if_fetch_done;
          end else if (bus.id_stall_req) begin
            stall = STALL_PAT_ID;
          end else if (bus.if_stall_req) begin
            stall = STALL_PAT_IF;
          end
        end
        PC_DRAIN: begin
          // PC holds the redirect target and ID holds a bubble while the
          // stale fetch is still outstanding.
          discard = 1'b1;
          stall   = bus.mem_stall_req ? STALL_PAT_MEM : STALL_PAT_IF;
          flush   = bus.ex_jump;
        end
        default: begin
          stall = STALL_PAT_NONE;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (in_reset),
    .inc   (stall[STALL_PC]),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (in_reset),
    .inc   (flush),
    .count (flush_cnt)
  );

  assign bus.stall_o         = stall;
  assign bus.flush_o         = flush;
  assign bus.discard_fetch_o = discard;
  // Debug and counter outputs are forced to zero while reset is held.
  assign bus.drain_o         = !in_reset && (state == PC_DRAIN);
  assign bus.stall_cycles_o  = in_reset ? '0 : stall_cnt;
  assign bus.flush_count_o   = in_reset ? '0 : flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline. It is the driver of the stall vector and flush signal that every inter-stage register (if_id, id_ex, ex_mem, mem_wb) samples. It arbitrates stall requests from IF, ID and MEM against the branch/jump redirect from EX. It tracks an in-flight instruction fetch that must be discarded after a redirect, and keeps saturating performance counters.

Parameters:
PIPE_N, 6, stall vector width (`PipelineNum); bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high (`ResetEnable = 1'b1)
if_stall_req  in  1  IF waiting on memory for current fetch
if_fetch_done  in  1  one-cycle pulse: outstanding fetch data returned
id_stall_req  in  1  load-use hazard detected in ID
mem_stall_req  in  1  MEM stage access not complete
ex_jump  in  1  EX resolved taken branch/jump (same signal as jump_i to id_ex)
stall_o  out  PIPE_N  stall vector to PC and all stage registers
flush_o  out  1  kill IF/ID and ID/EX contents this edge
discard_fetch_o  out  1  IF must drop the next if_fetch_done data
drain_o  out  1  FSM in DRAIN (debug)
stall_cycles_o  out  CNT_W  cycles with stall_o[0]=1
flush_count_o  out  CNT_W  cycles with flush_o=1

Behaviour:
- Stage register rule, fixed for all consumers: a stage register bubbles when stall[k]=1 and stall[k+1]=0. It holds when both bits are 1. It passes when stall[k]=0.
- stall_o, flush_o and discard_fetch_o are combinational from state and inputs. State and counters are registered.
- FSM states: RUN and DRAIN. Reset puts the FSM in RUN with both counters 0. While rst=1, all outputs are 0.
- RUN priority, highest first:
  1. mem_stall_req=1: stall_o=6'b011111, flush_o=0. An ex_jump in the same cycle is deferred; EX is frozen, so ex_jump re-presents itself after the stall clears.
  2. ex_jump=1: stall_o=0, flush_o=1. If if_stall_req=1 and if_fetch_done=0, go to DRAIN next cycle. If if_fetch_done=1 in the same cycle, the returned data is already dead, so discard_fetch_o=1 this cycle and stay in RUN.
  3. id_stall_req=1: stall_o=6'b000111, which bubbles EX for one cycle per asserted cycle.
  4. if_stall_req=1: stall_o=6'b000011, which bubbles ID.
  5. Otherwise stall_o=0.
- DRAIN:
  - discard_fetch_o=1.
  - stall_o=6'b011111 if mem_stall_req=1, else 6'b000011. PC holds the redirect target.
  - id_stall_req is ignored; ID holds a bubble.
  - if_fetch_done=1 returns the FSM to RUN next cycle. discard_fetch_o stays 1 in that cycle and drops the following cycle.
  - ex_jump in DRAIN cannot legally occur. If asserted, flush_o=1 and the FSM stays in DRAIN.
- Counters:
  - stall_cycles_o increments on every cycle with stall_o[0]=1 and rst=0.
  - flush_count_o increments on every cycle with flush_o=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-DRAIN: the FSM returns to RUN and discard_fetch_o is 0 the next cycle. IF is reset by the same rst, so no stale fetch survives.
- stall_o[5] is always 0.

Decomposition:
- Shared config.vh holds:
  - `PipelineNum and the stage bit indices: `STALL_PC=0 through `STALL_WB=5.
  - The encoded stall patterns: `STALL_NONE, `STALL_IF=6'b000011, `STALL_ID=6'b000111, `STALL_MEM=6'b011111.
  - The FSM state encodings: `PC_RUN and `PC_DRAIN.
  - The existing `ResetEnable.
- One sub-module is natural: sat_counter, parameterized by width with inc and clear inputs. It is instantiated twice.

Test Plan:
- Reset check: hold rst high for 2 cycles while all requests are 1 -> stall_o=0, flush_o=0, discard_fetch_o=0, both counters 0, drain_o=0.
- Load-use: assert id_stall_req for 1 cycle -> stall_o=6'b000111 for exactly 1 cycle, then 0; stall_cycles_o=1.
- Jump with fetch in flight: assert if_stall_req=1 and ex_jump=1 together, then pulse if_fetch_done 3 cycles later.
  - Jump cycle -> flush_o=1, stall_o=0.
  - Next 3 cycles -> drain_o=1, discard_fetch_o=1, stall_o=6'b000011.
  - After the done pulse -> RUN the following cycle; flush_count_o=1.
- MEM stall plus jump: assert mem_stall_req and ex_jump for 4 cycles, then drop mem_stall_req.
  - During the 4 cycles -> stall_o=6'b011111, flush_o=0.
  - First cycle after the drop -> flush_o=1.
- Jump coincident with fetch done: assert ex_jump=1, if_stall_req=1, if_fetch_done=1 together -> flush_o=1, discard_fetch_o=1, FSM stays in RUN.
- Saturation: preload stall_cycles to 2^CNT_W-2 (use CNT_W=4 in the bench), then hold if_stall_req for 5 cycles -> counter reaches 4'hF and holds.
